reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Parametrised reset sequencer for multi-DCM clock trees: waits for every lock input,
//  holds reset for a programmable time, then releases NUM_STAGES reset domains in order.
//  Re-pulses DCM reset on lock timeout; re-enters reset on lock loss or external request.
//  Sits beside the DCM/BUFG clock generator and drives all downstream domain resets.
// PARAMETERS
//  NUM_LOCKS       3         number of DCM LOCKED inputs, all ANDed
//  NUM_STAGES      3         number of sequentially released reset outputs
//  HOLD_CYCLES     16777215  cycles of stable lock before stage 0 release (>=1)
//  STAGE_GAP       16        cycles between consecutive stage releases (>=1)
//  LOCK_TIMEOUT    1048576   cycles waiting for lock before DCM reset pulse (>=2)
//  DCM_RST_CYCLES  8         width of dcm_rst_req pulse in cycles (>=1)
//  CNT_W           derived   $clog2 of largest count parameter plus 1 (localparam)
//  LOSS_W          8         width of saturating event counters
// PORTS
//  clk              in   1           free-running system clock (first BUFG output)
//  reset_n          in   1           asynchronous, active-low reset
//  reset_in         in   1           external reset request, async, active-high
//  lock_in          in   NUM_LOCKS   DCM LOCKED signals, async to clk
//  rst_out          out  NUM_STAGES  active-high domain resets; bit 0 released first
//  ready            out  1           1 when all stages released (state RUN)
//  dcm_rst_req      out  1           active-high DCM reset pulse
//  lock_loss_count  out  LOSS_W      saturating count of lock losses after HOLD entry
//  retry_count      out  LOSS_W      saturating count of DCM reset pulses issued
// BEHAVIOUR
//  - Reset (reset_n=0): state WAIT_LOCK, cnt=0, stage=0, rst_out all 1, ready=0,
//    dcm_rst_req=0, both counters 0, synchroniser flops 0. All outputs registered.
//  - reset_in and each lock_in pass a 2-flop synchroniser -> req_s, lock_s; all_lock=&lock_s.
//  - WAIT_LOCK: req_s -> stay, cnt=0. Else all_lock -> HOLD, cnt=0.
//    Else cnt++; at cnt==LOCK_TIMEOUT-1 -> DCM_RST, cnt=0.
//  - DCM_RST: dcm_rst_req=1 for exactly DCM_RST_CYCLES cycles; retry_count++ (sat) once
//    on entry; then -> WAIT_LOCK, cnt=0. req_s during DCM_RST does not shorten pulse.
//  - HOLD: cnt++; at cnt==HOLD_CYCLES-1 -> STAGE, rst_out[0]<=0, stage=0, cnt=0.
//  - STAGE: cnt++; at cnt==STAGE_GAP-1: stage++, rst_out[stage+1]<=0, cnt=0; when the
//    last bit is released -> RUN, ready<=1 on that same edge. NUM_STAGES=1: HOLD -> RUN.
//  - RUN: hold until abort.
//  - Abort (HOLD/STAGE/RUN): !all_lock or req_s -> next edge rst_out all 1, ready=0,
//    -> WAIT_LOCK, cnt=0. lock_loss_count++ (sat) only when !all_lock; simultaneous
//    req_s and lock loss counts as a loss. Abort takes priority over any terminal count.
//  - Release order invariant: rst_out[i]=0 implies rst_out[j]=0 for all j<i.
//  - Counters saturate at all-ones, never wrap; cleared only by reset_n.
//  - reset_n asserted mid-sequence: immediate async return to reset values.
//  - Latency: lock_in high to synchroniser output = 2 edges; all_lock to rst_out[0]=0
//    = HOLD_CYCLES+1 edges; to ready = HOLD_CYCLES+1+(NUM_STAGES-1)*STAGE_GAP.
// STRUCTURE
//  - Package clk_reset_pkg: state encoding (WAIT_LOCK, DCM_RST, HOLD, STAGE, RUN) as
//    localparams/typedef, shared with the clock generator's status logic.
//  - Sub-module sync_2ff (WIDTH param, async active-low clear): one instance of width
//    NUM_LOCKS+1 for {reset_in, lock_in}.
//  - Single shared cnt of width CNT_W plus stage index of $clog2(NUM_STAGES+1) bits.
// TESTING (HOLD_CYCLES=4, STAGE_GAP=2, NUM_STAGES=3, LOCK_TIMEOUT=10, DCM_RST_CYCLES=3)
//  - Locks high from reset release -> rst_out 111->110->100->000 at +2+5, +7, +9 edges;
//    ready=1 on the 000 edge; dcm_rst_req never asserts.
//  - Locks held low -> dcm_rst_req high exactly 3 cycles every 13 cycles; retry_count
//    1,2,3...; at 255 it stays 255 (LOSS_W=8).
//  - In RUN drop lock_in[1] for 1 cycle -> rst_out=111, ready=0 three edges later;
//    lock_loss_count=1; full sequence repeats after relock.
//  - reset_in pulse during STAGE (rst_out=110) -> rst_out=111, lock_loss_count unchanged;
//    sequence restarts after reset_in falls.
//  - Lock drop on the exact edge HOLD reaches terminal count -> rst_out stays 111, no release.
//  - reset_n low in RUN -> all outputs at reset values asynchronously, counters 0.

Source files
------------

// File: rtl/clk_reset_pkg.sv
// clk_reset_pkg: reset sequencer state encoding shared with clock generator status logic
package clk_reset_pkg;
    typedef enum logic [2:0] {WAIT_LOCK, DCM_RST, HOLD, STAGE, RUN} seq_state_t;
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with asynchronous active-low clear
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: waits for DCM lock, holds, then releases reset domains in order
module reset_sequencer
    import clk_reset_pkg::*;
#(
    parameter int NUM_LOCKS      = 3,
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 16777215,
    parameter int STAGE_GAP      = 16,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter int DCM_RST_CYCLES = 8,
    parameter int LOSS_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reset_in,
    input  logic [NUM_LOCKS-1:0]  lock_in,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  dcm_rst_req,
    output logic [LOSS_W-1:0]     lock_loss_count,
    output logic [LOSS_W-1:0]     retry_count
);
    localparam int CNT_W = $clog2(imax(imax(HOLD_CYCLES, STAGE_GAP), imax(LOCK_TIMEOUT, DCM_RST_CYCLES))) + 1;
    localparam int STG_W = $clog2(NUM_STAGES + 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TO_END   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DCM_END  = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES > 1 ? NUM_STAGES - 2 : 0);

    logic [NUM_LOCKS:0]    sync_q;
    logic                  req_s, all_lock, abort;
    seq_state_t            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [STG_W-1:0]      stage, stage_n;
    logic [NUM_STAGES-1:0] rst_next;
    logic [LOSS_W-1:0]     loss_n, retry_n;

    sync_2ff #(.WIDTH(NUM_LOCKS + 1)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     ({reset_in, lock_in}),
        .q     (sync_q)
    );

    assign req_s    = sync_q[NUM_LOCKS];
    assign all_lock = &sync_q[NUM_LOCKS-1:0];
    assign abort    = !all_lock || req_s;

    // Releasing the next domain is a left shift of the thermometer-coded reset vector
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        stage_n  = stage;
        rst_next = rst_out;
        retry_n  = retry_count;
        loss_n   = lock_loss_count;
        case (state)
            WAIT_LOCK: begin
                if (req_s) cnt_n = '0;
                else if (all_lock) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (cnt == TO_END) begin
                    state_n = DCM_RST;
                    cnt_n   = '0;
                    retry_n = &retry_count ? retry_count : retry_count + 1'b1;
                end
            end
            DCM_RST: begin
                if (cnt == DCM_END) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            HOLD: begin
                if (cnt == HOLD_END) begin
                    state_n  = (NUM_STAGES == 1) ? RUN : STAGE;
                    cnt_n    = '0;
                    stage_n  = '0;
                    rst_next = rst_out << 1;
                end
            end
            STAGE: begin
                if (cnt == GAP_END) begin
                    cnt_n    = '0;
                    stage_n  = stage + 1'b1;
                    rst_next = rst_out << 1;
                    if (stage == LAST_STG) state_n = RUN;
                end
            end
            RUN: cnt_n = '0;
            default: begin
                state_n  = WAIT_LOCK;
                cnt_n    = '0;
                rst_next = '1;
            end
        endcase
        // Abort wins over any terminal count reached on the same edge
        if ((state == HOLD || state == STAGE || state == RUN) && abort) begin
            state_n  = WAIT_LOCK;
            cnt_n    = '0;
            stage_n  = '0;
            rst_next = '1;
            if (!all_lock) loss_n = &lock_loss_count ? lock_loss_count : lock_loss_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            stage           <= '0;
            rst_out         <= '1;
            ready           <= 1'b0;
            dcm_rst_req     <= 1'b0;
            lock_loss_count <= '0;
            retry_count     <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            stage           <= stage_n;
            rst_out         <= rst_next;
            ready           <= (state_n == RUN);
            dcm_rst_req     <= (state_n == DCM_RST);
            lock_loss_count <= loss_n;
            retry_count     <= retry_n;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized scoreboard bench with a timestamp-based reference model
module tb_reset_sequencer;
    localparam int NL = 3, NS = 3, H = 4, G = 2, TO = 10, DC = 3, LW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          reset_in = 1'b0;
    logic [NL-1:0] lock_in = '1;
    logic [NS-1:0] rst_out;
    logic          ready, dcm_rst_req;
    logic [LW-1:0] lock_loss_count, retry_count;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_LOCKS(NL), .NUM_STAGES(NS), .HOLD_CYCLES(H), .STAGE_GAP(G),
        .LOCK_TIMEOUT(TO), .DCM_RST_CYCLES(DC), .LOSS_W(LW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .reset_in        (reset_in),
        .lock_in         (lock_in),
        .rst_out         (rst_out),
        .ready           (ready),
        .dcm_rst_req     (dcm_rst_req),
        .lock_loss_count (lock_loss_count),
        .retry_count     (retry_count)
    );

    typedef struct packed {
        logic [NS-1:0] rst;
        logic          rdy;
        logic          dcm;
        logic [LW-1:0] loss;
        logic [LW-1:0] retry;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0, failures = 0;

    // Model: modes 0=waiting for lock, 1=DCM pulse, 2=sequencing; all timing from edge stamps
    int          ecount = 0, mode = 0, wait_start = 0, seq_start = 0, pulse_start = 0;
    int          loss = 0, retry = 0;
    logic [NL:0] d1 = '0, d2 = '0;

    task automatic model_reset();
        mode = 0; wait_start = ecount; loss = 0; retry = 0; d1 = '0; d2 = '0;
    endtask

    task automatic model_step();
        logic [NL:0] s;
        bit req, lk;
        int e;
        e = ecount;
        s = d2; d2 = d1; d1 = {reset_in, lock_in};
        req = s[NL];
        lk = &s[NL-1:0];
        case (mode)
            0: if (req) wait_start = e;
               else if (lk) begin mode = 2; seq_start = e; end
               else if (e - wait_start == TO) begin
                   mode = 1; pulse_start = e;
                   if (retry < 255) retry++;
               end
            1: if (e - pulse_start == DC) begin mode = 0; wait_start = e; end
            default: if (!lk || req) begin
                   mode = 0; wait_start = e;
                   if (!lk && loss < 255) loss++;
               end
        endcase
    endtask

    function automatic exp_t cur_exp();
        exp_t x;
        int rel;
        logic [NS-1:0] ones;
        ones = '1;
        rel = (mode != 2 || ecount - seq_start < H) ? 0 : 1 + (ecount - seq_start - H) / G;
        if (rel > NS) rel = NS;
        x.rst = ones << rel;
        x.rdy = (rel == NS);
        x.dcm = (mode == 1);
        x.loss = LW'(loss);
        x.retry = LW'(retry);
        return x;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else begin
                ecount++;
                model_step();
            end
            exp_q.push_back(cur_exp());
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                while (exp_q.size() > 1) void'(exp_q.pop_front());
                mon_e = exp_q.pop_front();
                chk("rst_out", int'(rst_out), int'(mon_e.rst));
                chk("ready", int'(ready), int'(mon_e.rdy));
                chk("dcm_rst_req", int'(dcm_rst_req), int'(mon_e.dcm));
                chk("lock_loss_count", int'(lock_loss_count), int'(mon_e.loss));
                chk("retry_count", int'(retry_count), int'(mon_e.retry));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (14) @(negedge clk);
        lock_in[1] = 1'b0;
        @(negedge clk);
        lock_in[1] = 1'b1;
        repeat (16) @(negedge clk);
        do_reset();
        repeat (5) @(negedge clk);
        reset_in = 1'b1;
        repeat (4) @(negedge clk);
        reset_in = 1'b0;
        repeat (16) @(negedge clk);
        do_reset();
        repeat (4) @(negedge clk);
        lock_in[2] = 1'b0;
        repeat (2) @(negedge clk);
        lock_in = '1;
        repeat (16) @(negedge clk);
        lock_in = '0;
        do_reset();
        repeat (3400) @(negedge clk);
        lock_in = '1;
        repeat (20) @(negedge clk);
        repeat (400) begin
            @(negedge clk);
            lock_in  = ($urandom_range(0, 19) == 0) ? NL'($urandom) : '1;
            reset_in = ($urandom_range(0, 39) == 0);
        end
        lock_in = '1;
        reset_in = 1'b0;
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
